// File: rtl/link_serial_fifo.sv
// link_serial_fifo: link-port serial shift engine (master/slave clocking) with optional TX/RX burst FIFOs.
// Define LINK_EXT_TIMEOUT_EN to add a 16-bit watchdog on external-clock transfers.
module link_serial_fifo #(
   parameter int DATA_W = 8,
   parameter int FIFO_DEPTH = 4,
   parameter logic [8:0] CLK_DIV_SINGLE_SPEED = 9'd511,
   parameter logic [8:0] CLK_DIV_HIGH_SPEED = 9'd15,
   parameter int BURST_GAP = 8
) (
   input  logic              clk_sys,
   input  logic              rst,
   input  logic              ce,
   input  logic              sel_sb,
   input  logic              sel_sc,
   input  logic              cpu_wr_n,
   input  logic              sb_rd,
   input  logic [DATA_W-1:0] sb_in,
   input  logic              sc_start_in,
   input  logic              sc_speed_in,
   input  logic              sc_int_clock_in,
   input  logic              sc_burst_in,
   output logic [7:0]        sc_r,
   output logic [DATA_W-1:0] sb,
   input  logic              serial_clk_in,
   input  logic              serial_data_in,
   output logic              serial_clk_out,
   output logic              serial_data_out,
   output logic              serial_irq,
   output logic              sc_start,
   output logic              sc_int_clock
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(DATA_W + 1);
   localparam int GW = $clog2(BURST_GAP + 1);
   localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

   state_t state_q, state_d;
   logic sc_start_q, sc_start_d, sc_speed_q, sc_speed_d, sc_int_q, sc_int_d;
   logic sc_burst_q, sc_burst_d, rx_ovf_q, rx_ovf_d;
   logic clk_out_q, clk_out_d, data_out_q, data_out_d, irq_q, irq_d;
   logic sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
   logic [DATA_W-1:0] sr_q, sr_d, shifted, tx_head, rx_head;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [8:0] div_q, div_d, reload, half;
   logic [GW-1:0] gap_q, gap_d;
   logic [DATA_W-1:0] tx_mem_q [FIFO_DEPTH];
   logic [DATA_W-1:0] tx_mem_d [FIFO_DEPTH];
   logic [DATA_W-1:0] rx_mem_q [FIFO_DEPTH];
   logic [DATA_W-1:0] rx_mem_d [FIFO_DEPTH];
   logic [AW:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d, rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
   logic sc_wr, sb_wr, tx_empty, tx_full, rx_empty, rx_full, rise, fall;
   logic step, tx_pop, tx_push, rx_push, rx_pop;
`ifdef LINK_EXT_TIMEOUT_EN
   logic [15:0] wd_q, wd_d;
`endif

   assign sc_wr = sel_sc & ~cpu_wr_n;
   assign sb_wr = sel_sb & ~cpu_wr_n & ~sc_wr;
   assign tx_empty = tx_wp_q == tx_rp_q;
   assign tx_full = (tx_wp_q - tx_rp_q) == DEPTH;
   assign rx_empty = rx_wp_q == rx_rp_q;
   assign rx_full = (rx_wp_q - rx_rp_q) == DEPTH;
   assign tx_head = tx_mem_q[tx_rp_q[AW-1:0]];
   assign rx_head = rx_mem_q[rx_rp_q[AW-1:0]];
   assign rise = sync2_q & ~prev_q;
   assign fall = ~sync2_q & prev_q;
   assign reload = sc_speed_q ? CLK_DIV_HIGH_SPEED : CLK_DIV_SINGLE_SPEED;
   assign half = {1'b0, reload[8:1]} + 9'd1;
   assign shifted = {sr_q[DATA_W-2:0], serial_data_in};

   assign sc_r = {sc_start_q, rx_ovf_q, tx_full, sc_burst_q, ~rx_empty, 1'b1, sc_speed_q, sc_int_q};
   assign sb = sc_burst_q ? (rx_empty ? '0 : rx_head) : sr_q;
   assign serial_clk_out = clk_out_q;
   assign serial_data_out = data_out_q;
   assign serial_irq = irq_q;
   assign sc_start = sc_start_q;
   assign sc_int_clock = sc_int_q;

   always_comb begin
      state_d = state_q;
      sc_start_d = sc_start_q;
      sc_speed_d = sc_speed_q;
      sc_int_d = sc_int_q;
      sc_burst_d = sc_burst_q;
      rx_ovf_d = rx_ovf_q;
      clk_out_d = clk_out_q;
      data_out_d = data_out_q;
      irq_d = 1'b0;
      sync1_d = serial_clk_in;
      sync2_d = sync1_q;
      prev_d = sync2_q;
      sr_d = sr_q;
      cnt_d = cnt_q;
      div_d = div_q;
      gap_d = gap_q;
      tx_mem_d = tx_mem_q;
      rx_mem_d = rx_mem_q;
      tx_wp_d = tx_wp_q;
      rx_wp_d = rx_wp_q;
      step = 1'b0;
      tx_pop = 1'b0;
      rx_push = 1'b0;
      tx_push = sb_wr & sc_burst_q;
      rx_pop = sb_rd & sc_burst_q & ~rx_empty;
`ifdef LINK_EXT_TIMEOUT_EN
      wd_d = wd_q;
`endif
      if (sc_wr) begin
         sc_start_d = sc_start_in;
         sc_speed_d = sc_speed_in;
         sc_int_d = sc_int_clock_in;
         sc_burst_d = sc_burst_in;
         rx_ovf_d = 1'b0;
         clk_out_d = 1'b1;
         state_d = sc_start_in ? SHIFT : IDLE;
         cnt_d = sc_start_in ? CW'(DATA_W) : '0;
         div_d = sc_speed_in ? CLK_DIV_HIGH_SPEED : CLK_DIV_SINGLE_SPEED;
         tx_pop = sc_start_in & sc_burst_in & ~tx_empty;
         sr_d = tx_pop ? tx_head : sr_q;
`ifdef LINK_EXT_TIMEOUT_EN
         wd_d = '0;
`endif
      end else if (sb_wr && !sc_burst_q) begin
         sr_d = sb_in;
      end else if (state_q == SHIFT) begin
         if (sc_int_q) begin
            step = div_q == 9'd0;
            div_d = step ? reload : div_q - 9'd1;
            clk_out_d = step ? 1'b1 : (div_q == half ? 1'b0 : clk_out_q);
            data_out_d = (!step && div_q == half) ? sr_q[DATA_W-1] : data_out_q;
         end else begin
            step = rise;
            data_out_d = fall ? sr_q[DATA_W-1] : data_out_q;
`ifdef LINK_EXT_TIMEOUT_EN
            wd_d = (rise | fall) ? '0 : wd_q + 16'd1;
            if (!(rise | fall) && wd_q == 16'hFFFF) begin
               state_d = IDLE;
               sc_start_d = 1'b0;
               irq_d = 1'b1;
               rx_ovf_d = 1'b1;
               cnt_d = '0;
            end
`endif
         end
         if (step) begin
            sr_d = shifted;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               irq_d = 1'b1;
               rx_push = sc_burst_q;
               if (sc_burst_q && !tx_empty) begin
                  // Internal clock idles between words; external clock reloads right away.
                  if (sc_int_q) begin
                     state_d = GAP;
                     gap_d = GW'(BURST_GAP);
                  end else begin
                     sr_d = tx_head;
                     tx_pop = 1'b1;
                     cnt_d = CW'(DATA_W);
                  end
               end else begin
                  state_d = IDLE;
                  sc_start_d = 1'b0;
               end
            end
         end
      end else if (state_q == GAP) begin
         gap_d = gap_q - GW'(1);
         if (gap_q <= GW'(1)) begin
            state_d = SHIFT;
            cnt_d = CW'(DATA_W);
            div_d = reload;
            tx_pop = ~tx_empty;
            sr_d = tx_empty ? sr_q : tx_head;
         end
      end
      if (tx_push && (!tx_full || tx_pop)) begin
         tx_mem_d[tx_wp_q[AW-1:0]] = sb_in;
         tx_wp_d = tx_wp_q + 1'b1;
      end
      tx_rp_d = tx_rp_q + (AW+1)'(tx_pop);
      if (rx_push && (!rx_full || rx_pop)) begin
         rx_mem_d[rx_wp_q[AW-1:0]] = shifted;
         rx_wp_d = rx_wp_q + 1'b1;
      end else if (rx_push) begin
         rx_ovf_d = 1'b1;
      end
      rx_rp_d = rx_rp_q + (AW+1)'(rx_pop);
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         state_q <= IDLE;
         sc_start_q <= 1'b0;
         sc_speed_q <= 1'b0;
         sc_int_q <= 1'b0;
         sc_burst_q <= 1'b0;
         rx_ovf_q <= 1'b0;
         clk_out_q <= 1'b1;
         data_out_q <= 1'b1;
         irq_q <= 1'b0;
         sync1_q <= serial_clk_in;
         sync2_q <= serial_clk_in;
         prev_q <= serial_clk_in;
         sr_q <= '0;
         cnt_q <= '0;
         div_q <= '0;
         gap_q <= '0;
         tx_wp_q <= '0;
         tx_rp_q <= '0;
         rx_wp_q <= '0;
         rx_rp_q <= '0;
`ifdef LINK_EXT_TIMEOUT_EN
         wd_q <= '0;
`endif
      end else if (ce) begin
         state_q <= state_d;
         sc_start_q <= sc_start_d;
         sc_speed_q <= sc_speed_d;
         sc_int_q <= sc_int_d;
         sc_burst_q <= sc_burst_d;
         rx_ovf_q <= rx_ovf_d;
         clk_out_q <= clk_out_d;
         data_out_q <= data_out_d;
         irq_q <= irq_d;
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q <= prev_d;
         sr_q <= sr_d;
         cnt_q <= cnt_d;
         div_q <= div_d;
         gap_q <= gap_d;
         tx_wp_q <= tx_wp_d;
         tx_rp_q <= tx_rp_d;
         rx_wp_q <= rx_wp_d;
         rx_rp_q <= rx_rp_d;
`ifdef LINK_EXT_TIMEOUT_EN
         wd_q <= wd_d;
`endif
      end
   end

   always_ff @(posedge clk_sys) begin
      if (ce) begin
         tx_mem_q <= tx_mem_d;
         rx_mem_q <= rx_mem_d;
      end
   end
endmodule

// File: tb/tb_link_serial_fifo.sv
// tb_link_serial_fifo: directed checks of legacy, burst, external-clock, abort and reset behaviour.
module tb_link_serial_fifo;
   logic clk_sys = 1'b0, rst = 1'b1, ce = 1'b1;
   logic sel_sb = 1'b0, sel_sc = 1'b0, cpu_wr_n = 1'b1, sb_rd = 1'b0;
   logic [7:0] sb_in = '0;
   logic sc_start_in = 1'b0, sc_speed_in = 1'b0, sc_int_clock_in = 1'b0, sc_burst_in = 1'b0;
   logic serial_clk_in = 1'b1, din = 1'b1, loop = 1'b0;
   logic serial_data_in;
   logic [7:0] sc_r, sb, dlog = '0, pat;
   logic serial_clk_out, serial_data_out, serial_irq, sc_start, sc_int_clock;
   int n_cmp = 0, n_err = 0, cyc_n = 0, irq_cnt = 0, t0, b;
   int irq_t [32];

   assign serial_data_in = loop ? serial_data_out : din;

   link_serial_fifo dut (
      .clk_sys(clk_sys), .rst(rst), .ce(ce), .sel_sb(sel_sb), .sel_sc(sel_sc),
      .cpu_wr_n(cpu_wr_n), .sb_rd(sb_rd), .sb_in(sb_in), .sc_start_in(sc_start_in),
      .sc_speed_in(sc_speed_in), .sc_int_clock_in(sc_int_clock_in), .sc_burst_in(sc_burst_in),
      .sc_r(sc_r), .sb(sb), .serial_clk_in(serial_clk_in), .serial_data_in(serial_data_in),
      .serial_clk_out(serial_clk_out), .serial_data_out(serial_data_out),
      .serial_irq(serial_irq), .sc_start(sc_start), .sc_int_clock(sc_int_clock)
   );

   always #5 clk_sys = ~clk_sys;
   always @(posedge clk_sys) cyc_n++;
   always @(negedge clk_sys) begin
      if (serial_irq) begin
         if (irq_cnt < 32) irq_t[irq_cnt] = cyc_n;
         irq_cnt++;
      end
   end
   always @(posedge serial_clk_out) dlog = {dlog[6:0], serial_data_out};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk_sys);
      #1;
   endtask

   task automatic wr_sb(input logic [7:0] v);
      sel_sb = 1'b1; cpu_wr_n = 1'b0; sb_in = v;
      cyc(1);
      sel_sb = 1'b0; cpu_wr_n = 1'b1;
   endtask

   task automatic wr_sc(input logic st, input logic sp, input logic ic, input logic bu);
      sel_sc = 1'b1; cpu_wr_n = 1'b0;
      sc_start_in = st; sc_speed_in = sp; sc_int_clock_in = ic; sc_burst_in = bu;
      cyc(1);
      sel_sc = 1'b0; cpu_wr_n = 1'b1;
   endtask

   task automatic rd_sb();
      sb_rd = 1'b1;
      cyc(1);
      sb_rd = 1'b0;
   endtask

   task automatic wait_irq(input int target, input int budget, input string tag);
      int n = 0;
      while (irq_cnt < target && n < budget) begin
         cyc(1);
         n++;
      end
      check(tag, irq_cnt, target);
   endtask

   task automatic ext_edge_pair();
      serial_clk_in = 1'b0;
      cyc(6);
      serial_clk_in = 1'b1;
      cyc(6);
   endtask

   initial begin
      cyc(3);
      rst = 1'b0;
      cyc(1);
      check("rst_scr", sc_r, 8'h04);
      check("rst_sb", sb, 8'h00);
      check("rst_clk", serial_clk_out, 1'b1);
      check("rst_dout", serial_data_out, 1'b1);
      check("rst_irq", serial_irq, 1'b0);

      // legacy internal clock, normal speed
      din = 1'b1;
      wr_sb(8'hA5);
      dlog = '0;
      wr_sc(1'b1, 1'b0, 1'b1, 1'b0);
      t0 = cyc_n; b = irq_cnt;
      wait_irq(b + 1, 5000, "t1_irq");
      check("t1_lat", irq_t[b] - t0, 4096);
      check("t1_dout", dlog, 8'hA5);
      check("t1_sb", sb, 8'hFF);
      check("t1_start", sc_start, 1'b0);
      cyc(50);
      check("t1_one_irq", irq_cnt, b + 1);

      // burst internal clock, high speed, loopback
      loop = 1'b1;
      wr_sc(1'b0, 1'b1, 1'b1, 1'b1);
      wr_sb(8'h11); wr_sb(8'h22); wr_sb(8'h33);
      check("t2_scr", sc_r, 8'h17);
      wr_sc(1'b1, 1'b1, 1'b1, 1'b1);
      t0 = cyc_n; b = irq_cnt;
      wait_irq(b + 3, 1000, "t2_irqs");
      check("t2_lat", irq_t[b] - t0, 128);
      check("t2_sp1", irq_t[b+1] - irq_t[b], 136);
      check("t2_sp2", irq_t[b+2] - irq_t[b+1], 136);
      check("t2_start", sc_start, 1'b0);
      for (int i = 0; i < 3; i++) begin
         check("t2_rx", sb, 8'(8'h11 * (i + 1)));
         rd_sb();
      end
      check("t2_rx_empty", sb, 8'h00);
      check("t2_rxne", sc_r[3], 1'b0);

      // burst with TX full drop and RX overflow
      for (int i = 0; i < 4; i++) wr_sb(8'(i + 1));
      check("t3_txfull", sc_r[5], 1'b1);
      wr_sb(8'hEE);
      wr_sc(1'b1, 1'b1, 1'b1, 1'b1);
      wr_sb(8'h05);
      b = irq_cnt;
      wait_irq(b + 5, 2000, "t3_irqs");
      check("t3_ovf", sc_r[6], 1'b1);
      check("t3_start", sc_start, 1'b0);
      wr_sc(1'b0, 1'b1, 1'b1, 1'b1);
      check("t3_ovf_clr", sc_r[6], 1'b0);
      for (int i = 0; i < 4; i++) begin
         check("t3_rx", sb, 8'(i + 1));
         rd_sb();
      end
      check("t3_rx_empty", sb, 8'h00);

      // legacy external clock
      loop = 1'b0;
      wr_sc(1'b0, 1'b0, 1'b0, 1'b0);
      wr_sb(8'h00);
      wr_sc(1'b1, 1'b0, 1'b0, 1'b0);
      b = irq_cnt;
      pat = 8'h3C;
      for (int i = 7; i >= 0; i--) begin
         din = pat[i];
         ext_edge_pair();
      end
      wait_irq(b + 1, 50, "t4_irq");
      check("t4_sb", sb, 8'h3C);
      check("t4_scr", sc_r, 8'h04);
      wr_sc(1'b1, 1'b0, 1'b0, 1'b1);
      cyc(300);
      check("t4_wait_scr", sc_r, 8'h94);
      check("t4_wait_irq", irq_cnt, b + 1);
      wr_sc(1'b0, 1'b0, 1'b0, 1'b0);
      check("t4_abort_scr", sc_r, 8'h04);

      // abort after three bits, then a full restart
      din = 1'b0;
      wr_sb(8'hF0);
      wr_sc(1'b1, 1'b1, 1'b1, 1'b0);
      cyc(58);
      check("t5_mid_clk", serial_clk_out, 1'b0);
      b = irq_cnt;
      wr_sc(1'b0, 1'b1, 1'b1, 1'b0);
      check("t5_clk", serial_clk_out, 1'b1);
      check("t5_start", sc_start, 1'b0);
      check("t5_sb", sb, 8'h80);
      cyc(200);
      check("t5_no_irq", irq_cnt, b);
      wr_sb(8'hA5);
      wr_sc(1'b1, 1'b1, 1'b1, 1'b0);
      t0 = cyc_n;
      wait_irq(b + 1, 300, "t5_restart");
      check("t5_lat", irq_t[b] - t0, 128);
      check("t5_sb2", sb, 8'h00);

      // reset in the middle of a burst word
      wr_sc(1'b0, 1'b1, 1'b1, 1'b1);
      wr_sb(8'h77); wr_sb(8'h66);
      wr_sc(1'b1, 1'b1, 1'b1, 1'b1);
      cyc(40);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      check("t6_scr", sc_r, 8'h04);
      check("t6_sb", sb, 8'h00);
      check("t6_clk", serial_clk_out, 1'b1);
      check("t6_dout", serial_data_out, 1'b1);
      check("t6_irq", serial_irq, 1'b0);
      cyc(200);
      check("t6_no_irq", irq_cnt, b + 1);
      ce = 1'b0;
      wr_sc(1'b1, 1'b1, 1'b1, 1'b1);
      ce = 1'b1;
      check("t6_ce", sc_r, 8'h04);
      wr_sc(1'b0, 1'b0, 1'b0, 1'b1);
      check("t6_fifo_empty", sc_r, 8'h14);

`ifdef LINK_EXT_TIMEOUT_EN
      wr_sc(1'b0, 1'b0, 1'b0, 1'b0);
      wr_sc(1'b1, 1'b0, 1'b0, 1'b0);
      b = irq_cnt;
      ext_edge_pair();
      wait_irq(b + 1, 70000, "t7_irq");
      check("t7_ovf", sc_r[6], 1'b1);
      check("t7_start", sc_start, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
